// File: rtl/reg_file_param.sv
// Parametrised multi-read-port register file with a one-entry-per-cycle clear engine.
// Optional macro RF_REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_d;
  logic              wr_drop_d;
  logic              wr_en_c;
  logic              zero_wr_c;
  logic [DATA_W-1:0] mem [DEPTH];

  assign zero_wr_c = (ZERO_REG != 0) && (wa == '0);

  // State and control registers; reset restarts the sweep immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy      <= 1'b1;
      wr_drop   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy      <= busy_d;
      wr_drop   <= wr_drop_d;
    end
  end

  // Next-state logic and write qualification
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy;
    wr_drop_d = 1'b0;
    wr_en_c   = 1'b0;
    case (state_q)
      IDLE: begin
        wr_en_c = we && !zero_wr_c;
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end
      end
      CLEAR: begin
        wr_drop_d = we;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage array: the sweep owns the write port while clearing
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_en_c) begin
      mem[wa] <= wd;
    end
  end

  // Combinational read ports, forced to zero while clearing or on register 0
  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (!busy && !((ZERO_REG != 0) && (ra[i*ADDR_W +: ADDR_W] == '0))) begin
        rd[i*DATA_W +: DATA_W] = mem[ra[i*ADDR_W +: ADDR_W]];
`ifdef RF_REGFILE_BYPASS_EN
        if (wr_en_c && (wa == ra[i*ADDR_W +: ADDR_W])) begin
          rd[i*DATA_W +: DATA_W] = wd;
        end
`endif
      end
    end
  end

endmodule
